// File: rtl/sample_pkg.sv
// Shared definitions for the sample-clock generator / meter pair.
package sample_pkg;

    // Phase-accumulator width, common to generator and meter.
    localparam int ACC_W = 32;

    // Measurement controller states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GATE = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer for an asynchronous clock input followed by a delay
// flop, producing a one-cycle strobe on each synchronized rising edge.
module sync_edge_det (
    input  logic clk_in,
    input  logic RST_n,
    input  logic d_in,
    output logic rise
);

    logic s1_q, s2_q, s3_q;
    logic s1_d, s2_d, s3_d;

    // Shift the asynchronous input through the synchronizer and delay stage.
    always_comb begin
        s1_d = d_in;
        s2_d = s1_q;
        s3_d = s2_q;
    end

    // Synchronizer and delay flops; they run in every controller state.
    always_ff @(posedge clk_in or negedge RST_n) begin
        if (!RST_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    // Rising-edge strobe from the synchronized level and its delayed copy.
    always_comb begin
        rise = s2_q & ~s3_q;
    end

endmodule

// File: rtl/sample_fre_meter.sv
// Sample-rate meter: counts rising edges of clk_sample_in over a gate of
// 2^GATE_LOG2 clk_in cycles and scales the count into a 32-bit
// phase-accumulator control word (edge_cnt << (32 - GATE_LOG2)).
//
// GATE_LOG2 must lie in 2..31.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; counters hold
// GATE  | gate open: gate_cnt counts cycles, edge_cnt counts edges
// DONE  | one cycle: load result, pulse valid, re-arm if cont
module sample_fre_meter
    import sample_pkg::*;
#(
    parameter int GATE_LOG2 = 16
) (
    input  logic             clk_in,
    input  logic             RST_n,
    input  logic             start,
    input  logic             cont,
    input  logic             clk_sample_in,
    output logic [ACC_W-1:0] sample_fre,
    output logic             sample_valid,
    output logic             busy
);

    localparam int                   PAD_W     = ACC_W - GATE_LOG2;
    localparam logic [GATE_LOG2-1:0] GATE_LAST = '1;

    state_e                 state_q, state_d;
    logic [GATE_LOG2-1:0]   gate_cnt_q, gate_cnt_d;
    logic [GATE_LOG2-1:0]   edge_cnt_q, edge_cnt_d;
    logic [ACC_W-1:0]       sample_fre_q, sample_fre_d;
    logic                   sample_valid_q, sample_valid_d;
    logic                   rise;

    sync_edge_det u_sync (
        .clk_in (clk_in),
        .RST_n  (RST_n),
        .d_in   (clk_sample_in),
        .rise   (rise)
    );

    // State register and datapath flops; reset discards any result in flight.
    always_ff @(posedge clk_in or negedge RST_n) begin
        if (!RST_n) begin
            state_q        <= IDLE;
            gate_cnt_q     <= '0;
            edge_cnt_q     <= '0;
            sample_fre_q   <= '0;
            sample_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            gate_cnt_q     <= gate_cnt_d;
            edge_cnt_q     <= edge_cnt_d;
            sample_fre_q   <= sample_fre_d;
            sample_valid_q <= sample_valid_d;
        end
    end

    // Next-state logic; start is only honoured from IDLE, so it never queues.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start) state_d = GATE;
            GATE: if (gate_cnt_q == GATE_LAST) state_d = DONE;
            DONE: state_d = cont ? GATE : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Counter next values; the last gate cycle's edge lands in edge_cnt_q
    // before DONE reads it.
    always_comb begin
        gate_cnt_d = gate_cnt_q;
        edge_cnt_d = edge_cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    gate_cnt_d = '0;
                    edge_cnt_d = '0;
                end
            end
            GATE: begin
                gate_cnt_d = gate_cnt_q + 1'b1;
                edge_cnt_d = edge_cnt_q + rise;
            end
            DONE: begin
                if (cont) begin
                    gate_cnt_d = '0;
                    edge_cnt_d = '0;
                end
            end
            default: begin
                gate_cnt_d = '0;
                edge_cnt_d = '0;
            end
        endcase
    end

    // Output logic: result and valid pulse are loaded during DONE.
    always_comb begin
        sample_fre_d   = sample_fre_q;
        sample_valid_d = 1'b0;
        busy           = (state_q != IDLE);
        if (state_q == DONE) begin
            sample_fre_d   = {edge_cnt_q, {PAD_W{1'b0}}};
            sample_valid_d = 1'b1;
        end
    end

    assign sample_fre   = sample_fre_q;
    assign sample_valid = sample_valid_q;

endmodule
